sram_port_arbiter: RTL and testbench

//  Shares one like-SRAM memory port between the IF stage (inst requester, src 0) and the EXE/MEM

---
 rtl/sram_port_arbiter_pkg.sv | 21 ++
 rtl/sram_port_arbiter_if.sv | 26 ++
 rtl/sram_port_arbiter_arb_id_fifo.sv | 52 +++++
 rtl/sram_port_arbiter.sv | 119 +++++++++++
 tb/tb_sram_port_arbiter.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_port_arbiter_pkg.sv
// Shared constants for the IF/MEM SRAM port arbiter.
// Source ids, FSM encodings and the grant-selection rule.
package sram_port_arbiter_pkg;

  localparam logic SRC_INST = 1'b0;
  localparam logic SRC_DATA = 1'b1;

  localparam logic [0:0] ARB_IDLE   = 1'b0;
  localparam logic [0:0] ARB_LOCKED = 1'b1;

  // data wins unless inst has waited out a full streak
  function automatic logic pick_src(
    input logic inst_req,
    input logic data_req,
    input logic streak_hit
  );
    return (data_req && !(inst_req && streak_hit))
           ? SRC_DATA : SRC_INST;
  endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Like-SRAM request/response bundle.
// master drives the request, slave answers it.
interface sram_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  req;
  logic                  wr;
  logic [1:0]            size;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W/8-1:0]   wstrb;
  logic [DATA_W-1:0]     wdata;
  logic                  addr_ok;
  logic                  data_ok;
  logic [DATA_W-1:0]     rdata;

  modport master (
    output req, wr, size, addr, wstrb, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wstrb, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_port_arbiter_arb_id_fifo.sv
// In-order tracker of outstanding request sources.
// 1-bit wide, DEPTH-deep (power of 2) synchronous FIFO.
module arb_id_fifo #(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          push,
  input  logic          din,
  input  logic          pop,
  output logic          head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [DEPTH-1:0] r_mem;
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [CW-1:0]    r_cnt;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_cnt == CW'(DEPTH));
  assign empty  = (r_cnt == '0);
  assign count  = r_cnt;
  assign head   = r_mem[r_rp];
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= din;
        r_wp        <= r_wp + AW'(1);
      end
      if (w_pop) r_rp <= r_rp + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one like-SRAM port between the IF (inst) and EXE/MEM (data)
// requesters; responses are routed back in acceptance order.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int OUTSTANDING = 4,
  parameter int STREAK_MAX  = 4
) (
  input  logic                clk,
  input  logic                resetn,
  sram_port_arbiter_if.slave  i_port,
  sram_port_arbiter_if.slave  d_port,
  sram_port_arbiter_if.master m_port,
  output logic                err_orphan
);

  localparam int CW = $clog2(OUTSTANDING) + 1;
  localparam int SW = $clog2(STREAK_MAX + 1);

  logic [0:0]    r_state;
  logic          r_src;
  logic [SW-1:0] r_streak;
  logic          r_err;

  logic          w_full;
  logic          w_empty;
  logic          w_head;
  logic [CW-1:0] w_count;
  logic          w_sel;
  logic          w_req;
  logic          w_acc;
  logic          w_pop;
  logic          w_orphan;
  logic          w_hit;

  assign w_hit = (r_streak == SW'(STREAK_MAX));

  // full is sampled before any same-cycle pop: no data_ok->req path
  always_comb begin
    w_sel = r_src;
    w_req = 1'b0;
    if (r_state == ARB_LOCKED) begin
      w_req = resetn;
    end else begin
      w_sel = pick_src(i_port.req, d_port.req, w_hit);
      w_req = resetn & ~w_full & (i_port.req | d_port.req);
    end
  end

  assign m_port.req   = w_req;
  assign m_port.wr    = w_sel ? d_port.wr    : i_port.wr;
  assign m_port.size  = w_sel ? d_port.size  : i_port.size;
  assign m_port.addr  = w_sel ? d_port.addr  : i_port.addr;
  assign m_port.wstrb = w_sel ? d_port.wstrb : i_port.wstrb;
  assign m_port.wdata = w_sel ? d_port.wdata : i_port.wdata;

  assign w_acc          = w_req & m_port.addr_ok;
  assign i_port.addr_ok = w_acc & (w_sel == SRC_INST);
  assign d_port.addr_ok = w_acc & (w_sel == SRC_DATA);

  assign w_pop          = resetn & m_port.data_ok & ~w_empty;
  assign w_orphan       = m_port.data_ok & w_empty;
  assign i_port.data_ok = w_pop & (w_head == SRC_INST);
  assign d_port.data_ok = w_pop & (w_head == SRC_DATA);
  assign i_port.rdata   = m_port.rdata;
  assign d_port.rdata   = m_port.rdata;
  assign err_orphan     = r_err;

  arb_id_fifo #(
    .DEPTH (OUTSTANDING)
  ) u_ids (
    .clk    (clk),
    .resetn (resetn),
    .push   (w_acc),
    .din    (w_sel),
    .pop    (w_pop),
    .head   (w_head),
    .count  (w_count),
    .full   (w_full),
    .empty  (w_empty)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state  <= ARB_IDLE;
      r_src    <= SRC_INST;
      r_streak <= '0;
      r_err    <= 1'b0;
    end else begin
      if (r_state == ARB_IDLE && w_req && !m_port.addr_ok) begin
        r_state <= ARB_LOCKED;
        r_src   <= w_sel;
      end else if (w_acc) begin
        r_state <= ARB_IDLE;
      end
      if (!i_port.req)
        r_streak <= '0;
      else if (w_acc && w_sel == SRC_INST)
        r_streak <= '0;
      else if (w_acc && !w_hit)
        r_streak <= r_streak + SW'(1);
      if (w_orphan) r_err <= 1'b1;
    end
  end

  a_count: assert property (
    @(posedge clk) disable iff (!resetn)
    w_count <= CW'(OUTSTANDING)
  );

  a_hold: assert property (
    @(posedge clk) disable iff (!resetn)
    (r_state == ARB_LOCKED) |->
      (r_src ? d_port.req : i_port.req)
  );

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomized bench for sram_port_arbiter against a queue-based
// model of grant, tracking and response routing.
module tb_sram_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int OUT  = 4;
  localparam int SMAX = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic err_orphan;

  always #5 clk = ~clk;

  sram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ib ();
  sram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) db ();
  sram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) mb ();

  sram_port_arbiter #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .OUTSTANDING (OUT),
    .STREAK_MAX  (SMAX)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .i_port     (ib.slave),
    .d_port     (db.slave),
    .m_port     (mb.master),
    .err_orphan (err_orphan)
  );

  bit   q[$];
  int   streak;
  int   owner;
  bit   err_m;
  bit   i_acc;
  bit   d_acc;
  int   n_vec;
  int   n_bad;
  int   n_acc;
  logic [9:0] pat;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // called at posedge+1 with inputs driven; returns at next posedge+1
  task automatic step();
    bit exp_req;
    bit src;
    bit acc;
    bit pop;
    bit orph;
    bit hd;
    #1;
    exp_req = 1'b0;
    src     = 1'b0;
    if (owner >= 0) begin
      exp_req = 1'b1;
      src     = owner[0];
    end else if (q.size() < OUT && (ib.req || db.req)) begin
      exp_req = 1'b1;
      src     = db.req && !(ib.req && streak == SMAX);
    end
    chk("m_req", mb.req, exp_req);
    if (exp_req) begin
      chk("m_addr", mb.addr, src ? db.addr : ib.addr);
      chk("m_ctl", {mb.wr, mb.size, mb.wstrb},
          src ? {db.wr, db.size, db.wstrb} : {ib.wr, ib.size, ib.wstrb});
      chk("m_wdata", mb.wdata, src ? db.wdata : ib.wdata);
    end
    acc = exp_req && mb.addr_ok;
    chk("i_addr_ok", ib.addr_ok, acc && !src);
    chk("d_addr_ok", db.addr_ok, acc && src);
    pop  = mb.data_ok && q.size() > 0;
    orph = mb.data_ok && q.size() == 0;
    hd   = (q.size() > 0) ? q[0] : 1'b0;
    chk("i_data_ok", ib.data_ok, pop && !hd);
    chk("d_data_ok", db.data_ok, pop && hd);
    if (pop) begin
      chk("i_rdata", ib.rdata, mb.rdata);
      chk("d_rdata", db.rdata, mb.rdata);
    end
    chk("err_orphan", err_orphan, err_m);
    i_acc = acc && !src;
    d_acc = acc && src;
    if (pop) void'(q.pop_front());
    if (acc) q.push_back(src);
    owner = (exp_req && !mb.addr_ok) ? int'(src) : -1;
    if (!ib.req || i_acc) streak = 0;
    else if (d_acc && streak < SMAX) streak++;
    if (orph) err_m = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic new_i();
    ib.req   = 1'b1;
    ib.wr    = 1'($urandom);
    ib.size  = 2'($urandom_range(2));
    ib.addr  = $urandom;
    ib.wstrb = 4'($urandom);
    ib.wdata = $urandom;
  endtask

  task automatic new_d();
    db.req   = 1'b1;
    db.wr    = 1'($urandom);
    db.size  = 2'($urandom_range(2));
    db.addr  = $urandom;
    db.wstrb = 4'($urandom);
    db.wdata = $urandom;
  endtask

  // payload is held until accepted; afterwards maybe issue a new one
  task automatic refill(int pi, int pd);
    if (!ib.req || i_acc) begin
      if (int'($urandom_range(99)) < pi) new_i();
      else ib.req = 1'b0;
    end
    if (!db.req || d_acc) begin
      if (int'($urandom_range(99)) < pd) new_d();
      else db.req = 1'b0;
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 20; k++) begin
      if (!ib.req && !db.req && q.size() == 0) break;
      mb.addr_ok = 1'b1;
      mb.data_ok = (q.size() > 0);
      mb.rdata   = $urandom;
      step();
      refill(0, 0);
    end
    mb.addr_ok = 1'b0;
    mb.data_ok = 1'b0;
    chk("drained", q.size(), 0);
  endtask

  task automatic do_reset();
    resetn     = 1'b0;
    new_i();
    db.req     = 1'b0;
    mb.addr_ok = 1'b1;
    mb.data_ok = 1'b1;
    mb.rdata   = $urandom;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_m_req", mb.req, 0);
    chk("rst_addr_ok", {ib.addr_ok, db.addr_ok}, 0);
    chk("rst_data_ok", {ib.data_ok, db.data_ok}, 0);
    chk("rst_err", err_orphan, 0);
    @(posedge clk);
    #1;
    resetn     = 1'b1;
    ib.req     = 1'b0;
    mb.addr_ok = 1'b0;
    mb.data_ok = 1'b0;
    q.delete();
    streak = 0;
    owner  = -1;
    err_m  = 1'b0;
    i_acc  = 1'b0;
    d_acc  = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    {ib.req, ib.wr, ib.size, ib.addr, ib.wstrb, ib.wdata} = '0;
    {db.req, db.wr, db.size, db.addr, db.wstrb, db.wdata} = '0;
    {mb.addr_ok, mb.data_ok, mb.rdata} = '0;
    @(posedge clk);
    #1;
    do_reset();

    // single inst read, response two cycles later
    ib.req = 1'b1; ib.wr = 1'b0; ib.size = 2'd2;
    ib.addr = 32'h1C00_0000; ib.wstrb = 4'h0; ib.wdata = '0;
    mb.addr_ok = 1'b1;
    step();
    refill(0, 0);
    mb.addr_ok = 1'b0;
    step();
    mb.data_ok = 1'b1;
    mb.rdata   = 32'h0280_0C0C;
    #1;
    chk("t1_rdata", ib.rdata, 32'h0280_0C0C);
    step();
    mb.data_ok = 1'b0;

    // simultaneous requests: data first, inst next
    new_i();
    new_d();
    db.wr = 1'b1; db.addr = 32'h1C0; db.wstrb = 4'hF;
    mb.addr_ok = 1'b1;
    step();
    chk("t2_d_first", d_acc, 1);
    refill(0, 0);
    step();
    chk("t2_i_next", i_acc, 1);
    refill(0, 0);
    drain();

    // stalled data grant must not switch when inst arrives
    new_d();
    mb.addr_ok = 1'b0;
    step();
    new_i();
    step();
    step();
    mb.addr_ok = 1'b1;
    step();
    chk("t3_d_kept", d_acc, 1);
    refill(0, 0);
    step();
    refill(0, 0);
    drain();

    // tracker fills after OUT accepts; one pop reopens next cycle
    n_acc = 0;
    new_i();
    new_d();
    mb.addr_ok = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      n_acc += int'(i_acc) + int'(d_acc);
      refill(100, 100);
    end
    chk("t4_accepts", n_acc, OUT);
    mb.data_ok = 1'b1;
    step();
    chk("t4_full_pop", i_acc | d_acc, 0);
    mb.data_ok = 1'b0;
    step();
    chk("t4_reopen", i_acc | d_acc, 1);
    refill(0, 0);
    drain();

    // starvation guard pattern
    pat = '0;
    new_i();
    new_d();
    mb.addr_ok = 1'b1;
    for (int k = 0; k < 10; k++) begin
      mb.data_ok = (q.size() > 0);
      mb.rdata   = $urandom;
      step();
      pat = {pat[8:0], d_acc};
      refill(100, 100);
    end
    chk("t5_pattern", pat, 10'b11110_11110);
    refill(0, 0);
    drain();

    // random traffic
    for (int k = 0; k < 2000; k++) begin
      mb.addr_ok = ($urandom_range(3) != 0);
      mb.data_ok = (q.size() > 0) && ($urandom_range(1) == 1);
      mb.rdata   = $urandom;
      step();
      refill(60, 60);
    end
    refill(0, 0);
    drain();

    // orphan response, then reset clears flag and tracker
    mb.data_ok = 1'b1;
    step();
    mb.data_ok = 1'b0;
    step();
    chk("t6_orphan", err_orphan, 1);
    new_d();
    mb.addr_ok = 1'b1;
    step();
    refill(0, 0);
    mb.addr_ok = 1'b0;
    step();
    do_reset();
    mb.data_ok = 1'b1;
    step();
    mb.data_ok = 1'b0;
    step();
    chk("t6_post_rst", err_orphan, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
